// File: rtl/ahb_mem_slave.sv
// AHB-Lite responder backed by a word-addressed memory. Inserts a fixed number of
// wait states on OKAY transfers and gives a two-cycle ERROR for bad addresses.
//
// state | meaning
// IDLE  | ready; completes a pending zero-wait data phase, samples address phase
// WAIT  | HREADYOUT low, counting down wait states; address phase ignored
// LAST  | final data-phase cycle after waits; samples next address phase
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high; samples next address phase
module ahb_mem_slave #(
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic [1:0]  HRESP
);

   localparam int unsigned AW      = $clog2(MEM_DEPTH);
   localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [1:0]  RESP_OKAY  = 2'b00;
   localparam logic [1:0]  RESP_ERROR = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LAST,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic          dp_ok_q;
   logic          dp_write_q;
   logic [AW-1:0] dp_word_q;
   logic          hreadyout_q;
   logic [1:0]    hresp_q;
   logic [31:0]   mem_q [MEM_DEPTH];

   logic can_sample;
   logic accept;
   logic addr_err;
   logic done;
   logic unused_htrans;

   assign unused_htrans = HTRANS[0];

   assign can_sample = (state_q == S_IDLE) || (state_q == S_LAST) || (state_q == S_ERR2);
   assign accept     = can_sample & HSEL & HREADY & HTRANS[1];
   assign addr_err   = (HADDR[1:0] != 2'b00) || (HADDR[31:AW+2] != '0);
   // An OKAY data phase completes in whichever cycle this slave is ready.
   assign done       = dp_ok_q & hreadyout_q;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dp_ok_q     <= 1'b0;
         dp_write_q  <= 1'b0;
         dp_word_q   <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= RESP_OKAY;
      end else begin
         case (state_q)
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= S_LAST;
                  hreadyout_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_ERR1: begin
               state_q     <= S_ERR2;
               hreadyout_q <= 1'b1;
               hresp_q     <= RESP_ERROR;
            end
            default: begin
               state_q     <= S_IDLE;
               dp_ok_q     <= 1'b0;
               dp_write_q  <= 1'b0;
               hreadyout_q <= 1'b1;
               hresp_q     <= RESP_OKAY;
               if (accept) begin
                  dp_word_q <= HADDR[AW+1:2];
                  if (addr_err) begin
                     state_q     <= S_ERR1;
                     hreadyout_q <= 1'b0;
                     hresp_q     <= RESP_ERROR;
                  end else begin
                     dp_ok_q    <= 1'b1;
                     dp_write_q <= HWRITE;
                     if (WAIT_STATES > 0) begin
                        state_q     <= S_WAIT;
                        cnt_q       <= WS_LOAD;
                        hreadyout_q <= 1'b0;
                     end
                  end
               end
            end
         endcase
      end
   end

   // The write lands on the edge that accepts any following read, so a
   // combinational read in that read's completion cycle already sees it.
   always_ff @(posedge HCLK) begin
      if (!HRESET && done && dp_write_q) begin
         mem_q[dp_word_q] <= HWDATA;
      end
   end

   assign HRDATA    = (done && !dp_write_q) ? mem_q[dp_word_q] : 32'h0;
   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: directed table on a zero-wait instance, hand sequences on a
// three-wait instance, then random traffic on both against a transfer-level model.
module tb_ahb_mem_slave;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_BUSY = 2'b01;
   localparam logic [1:0] T_NSQ  = 2'b10;
   localparam logic [1:0] R_OK   = 2'b00;
   localparam logic [1:0] R_ERR  = 2'b01;
   localparam int K_NONE  = 0;
   localparam int K_READ  = 1;
   localparam int K_WRITE = 2;

   typedef struct {
      logic        rst;
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rdy_in;
      logic        e_rdy;
      logic [1:0]  e_resp;
      logic [31:0] e_rdata;
   } vec_t;

   typedef struct {
      logic       rdy;
      logic [1:0] resp;
      int         kind;
      logic [7:0] word;
   } exp_t;

   logic        HCLK = 1'b0;
   logic        rst_r   [2];
   logic        sel_r   [2];
   logic [1:0]  trans_r [2];
   logic        wr_r    [2];
   logic [31:0] addr_r  [2];
   logic [31:0] wdata_r [2];
   logic        rdy_r   [2];

   logic        hro0, hro3;
   logic [31:0] hrd0, hrd3;
   logic [1:0]  hrs0, hrs3;

   int n_chk  = 0;
   int n_pass = 0;

   exp_t        exp_q [$];
   logic [31:0] mm [256];

   always #5 HCLK = ~HCLK;

   ahb_mem_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
      .HCLK(HCLK), .HRESET(rst_r[0]), .HSEL(sel_r[0]), .HTRANS(trans_r[0]),
      .HWRITE(wr_r[0]), .HADDR(addr_r[0]), .HWDATA(wdata_r[0]), .HREADY(rdy_r[0]),
      .HREADYOUT(hro0), .HRDATA(hrd0), .HRESP(hrs0)
   );

   ahb_mem_slave #(.MEM_DEPTH(256), .WAIT_STATES(3)) u_dut3 (
      .HCLK(HCLK), .HRESET(rst_r[1]), .HSEL(sel_r[1]), .HTRANS(trans_r[1]),
      .HWRITE(wr_r[1]), .HADDR(addr_r[1]), .HWDATA(wdata_r[1]), .HREADY(rdy_r[1]),
      .HREADYOUT(hro3), .HRDATA(hrd3), .HRESP(hrs3)
   );

   function automatic vec_t mk(input logic rst, input logic sel, input logic [1:0] tr,
                               input logic wr, input logic [31:0] a, input logic [31:0] wd,
                               input logic rdy, input logic er, input logic [1:0] eresp,
                               input logic [31:0] erd);
      vec_t v;
      v.rst = rst; v.sel = sel; v.trans = tr; v.wr = wr; v.addr = a; v.wdata = wd;
      v.rdy_in = rdy; v.e_rdy = er; v.e_resp = eresp; v.e_rdata = erd;
      return v;
   endfunction

   task automatic drv(input int d, input logic rst, input logic sel, input logic [1:0] tr,
                      input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic rdy);
      rst_r[d] = rst; sel_r[d] = sel; trans_r[d] = tr; wr_r[d] = wr;
      addr_r[d] = a; wdata_r[d] = wd; rdy_r[d] = rdy;
   endtask

   task automatic check(input int d, input string nm, input logic e_rdy,
                        input logic [1:0] e_resp, input logic [31:0] e_rd);
      logic        a_rdy;
      logic [1:0]  a_resp;
      logic [31:0] a_rd;
      a_rdy  = (d == 0) ? hro0 : hro3;
      a_resp = (d == 0) ? hrs0 : hrs3;
      a_rd   = (d == 0) ? hrd0 : hrd3;
      n_chk++;
      if ({a_rdy, a_resp, a_rd} === {e_rdy, e_resp, e_rd}) n_pass++;
      else $display("FAIL %s dut%0d @%0t: got rdy=%b resp=%b rdata=%h, want rdy=%b resp=%b rdata=%h",
                    nm, d, $time, a_rdy, a_resp, a_rd, e_rdy, e_resp, e_rd);
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   // One bus cycle against the transfer-level model: drive, check, then advance the model.
   task automatic bus_cycle(input int d, input int ws, input logic sel, input logic [1:0] tr,
                            input logic wr, input logic [31:0] a, input logic stall,
                            input string nm, output logic acc);
      exp_t        e;
      exp_t        p;
      logic [31:0] wd;
      logic        hr;
      logic [31:0] er;
      if (exp_q.size() > 0) e = exp_q[0];
      else begin
         e.rdy = 1'b1; e.resp = R_OK; e.kind = K_NONE; e.word = '0;
      end
      wd = $urandom();
      hr = (stall && exp_q.size() == 0) ? 1'b0 : e.rdy;
      drv(d, 1'b0, sel, tr, wr, a, wd, hr);
      @(negedge HCLK);
      er = (e.kind == K_READ) ? mm[e.word] : 32'h0;
      check(d, nm, e.rdy, e.resp, er);
      acc = sel && hr && tr[1];
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (e.kind == K_WRITE) mm[e.word] = wd;
      if (acc) begin
         if (a[1:0] != 2'b00 || a >= 32'h400) begin
            p.rdy = 1'b0; p.resp = R_ERR; p.kind = K_NONE; p.word = '0;
            exp_q.push_back(p);
            p.rdy = 1'b1;
            exp_q.push_back(p);
         end else begin
            p.rdy = 1'b0; p.resp = R_OK; p.kind = K_NONE; p.word = a[9:2];
            repeat (ws) exp_q.push_back(p);
            p.rdy = 1'b1; p.kind = wr ? K_WRITE : K_READ;
            exp_q.push_back(p);
         end
      end
      tick();
   endtask

   vec_t vt [19];

   initial begin
      logic        acc;
      logic [31:0] a;
      int          r;

      vt[0]  = mk(1, 0, T_IDLE, 0, 32'h0,   32'h0,        1, 1, R_OK,  32'h0);
      vt[1]  = mk(1, 0, T_IDLE, 0, 32'h0,   32'h0,        1, 1, R_OK,  32'h0);
      vt[2]  = mk(0, 1, T_NSQ,  1, 32'h10,  32'h0,        1, 1, R_OK,  32'h0);
      vt[3]  = mk(0, 1, T_NSQ,  0, 32'h10,  32'hDEADBEEF, 1, 1, R_OK,  32'h0);
      vt[4]  = mk(0, 1, T_NSQ,  1, 32'h20,  32'h0,        1, 1, R_OK,  32'hDEADBEEF);
      vt[5]  = mk(0, 1, T_NSQ,  0, 32'h20,  32'h12345678, 1, 1, R_OK,  32'h0);
      vt[6]  = mk(0, 1, T_NSQ,  1, 32'h0,   32'h0,        1, 1, R_OK,  32'h12345678);
      vt[7]  = mk(0, 1, T_NSQ,  0, 32'h402, 32'hA5A5A5A5, 1, 1, R_OK,  32'h0);
      vt[8]  = mk(0, 1, T_IDLE, 0, 32'h0,   32'h0,        0, 0, R_ERR, 32'h0);
      vt[9]  = mk(0, 1, T_NSQ,  1, 32'h400, 32'h0,        1, 1, R_ERR, 32'h0);
      vt[10] = mk(0, 1, T_IDLE, 0, 32'h0,   32'hFFFFFFFF, 0, 0, R_ERR, 32'h0);
      vt[11] = mk(0, 1, T_NSQ,  0, 32'h10,  32'hFFFFFFFF, 1, 1, R_ERR, 32'h0);
      vt[12] = mk(0, 0, T_NSQ,  1, 32'h0,   32'h0,        1, 1, R_OK,  32'hDEADBEEF);
      vt[13] = mk(0, 1, T_NSQ,  1, 32'h0,   32'h11111111, 0, 1, R_OK,  32'h0);
      vt[14] = mk(0, 1, T_IDLE, 1, 32'h0,   32'h22222222, 1, 1, R_OK,  32'h0);
      vt[15] = mk(0, 1, T_BUSY, 1, 32'h0,   32'h33333333, 1, 1, R_OK,  32'h0);
      vt[16] = mk(0, 1, T_NSQ,  0, 32'h0,   32'h44444444, 1, 1, R_OK,  32'h0);
      vt[17] = mk(0, 1, T_IDLE, 0, 32'h0,   32'h0,        1, 1, R_OK,  32'hA5A5A5A5);
      vt[18] = mk(0, 0, T_IDLE, 0, 32'h0,   32'h0,        1, 1, R_OK,  32'h0);

      drv(1, 1, 0, T_IDLE, 0, 32'h0, 32'h0, 1);

      // zero-wait instance: directed table
      for (int i = 0; i < 19; i++) begin
         drv(0, vt[i].rst, vt[i].sel, vt[i].trans, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].rdy_in);
         @(negedge HCLK);
         check(0, $sformatf("tbl[%0d]", i), vt[i].e_rdy, vt[i].e_resp, vt[i].e_rdata);
         tick();
      end
      drv(0, 0, 0, T_IDLE, 0, 32'h0, 32'h0, 1);

      // three-wait instance: write then pipelined read, stray address phases during waits
      drv(1, 0, 1, T_NSQ, 1, 32'h04, 32'h0, 1);
      @(negedge HCLK); check(1, "ws3_rst", 1, R_OK, 32'h0); tick();
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, 1, T_NSQ, 1, 32'h08, 32'hCAFEF00D, 1);
         @(negedge HCLK); check(1, $sformatf("ws3_wr_wait%0d", i), 0, R_OK, 32'h0); tick();
      end
      drv(1, 0, 1, T_NSQ, 0, 32'h04, 32'hCAFEF00D, 1);
      @(negedge HCLK); check(1, "ws3_wr_done", 1, R_OK, 32'h0); tick();
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, 1, 2'b11, 1, 32'h0C, 32'h55555555, 1);
         @(negedge HCLK); check(1, $sformatf("ws3_rd_wait%0d", i), 0, R_OK, 32'h0); tick();
      end
      drv(1, 0, 1, T_IDLE, 0, 32'h0, 32'h0, 1);
      @(negedge HCLK); check(1, "ws3_rd_done", 1, R_OK, 32'hCAFEF00D); tick();
      drv(1, 0, 1, T_NSQ, 0, 32'h402, 32'h0, 1);
      @(negedge HCLK); check(1, "ws3_no_extra", 1, R_OK, 32'h0); tick();
      drv(1, 0, 1, T_IDLE, 0, 32'h0, 32'h0, 0);
      @(negedge HCLK); check(1, "ws3_err1", 0, R_ERR, 32'h0); tick();
      drv(1, 0, 1, T_NSQ, 1, 32'h04, 32'h0, 1);
      @(negedge HCLK); check(1, "ws3_err2", 1, R_ERR, 32'h0); tick();

      // reset during the second wait cycle of a write to 0x04
      drv(1, 0, 1, T_IDLE, 0, 32'h0, 32'h99999999, 0);
      @(negedge HCLK); check(1, "ws3_rw_wait0", 0, R_OK, 32'h0); tick();
      drv(1, 1, 1, T_IDLE, 0, 32'h0, 32'h99999999, 0);
      @(negedge HCLK); check(1, "ws3_rw_wait1", 0, R_OK, 32'h0); tick();
      drv(1, 0, 1, T_NSQ, 0, 32'h04, 32'h99999999, 1);
      @(negedge HCLK); check(1, "ws3_after_rst", 1, R_OK, 32'h0); tick();
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, 1, T_IDLE, 0, 32'h0, 32'h99999999, 0);
         @(negedge HCLK); check(1, "ws3_rd2_wait", 0, R_OK, 32'h0); tick();
      end
      drv(1, 0, 0, T_IDLE, 0, 32'h0, 32'h0, 1);
      @(negedge HCLK); check(1, "ws3_kept_old", 1, R_OK, 32'hCAFEF00D); tick();

      // random traffic on each instance against the model
      for (int d = 0; d < 2; d++) begin
         int ws;
         ws = (d == 0) ? 0 : 3;
         drv(d, 1, 0, T_IDLE, 0, 32'h0, 32'h0, 1);
         tick();
         @(negedge HCLK); check(d, "rnd_rst", 1, R_OK, 32'h0); tick();
         exp_q.delete();
         for (int w = 0; w < 16; w++) begin
            acc = 1'b0;
            for (int t = 0; t < 8 && !acc; t++)
               bus_cycle(d, ws, 1'b1, T_NSQ, 1'b1, 32'(w) * 4, 1'b0, "fill", acc);
         end
         for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = 32'($urandom_range(0, 15)) * 4;
            else if (r < 8) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            else if (r < 9) a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
            else            a = $urandom() | 32'h8000_0000;
            bus_cycle(d, ws, ($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), a, ($urandom_range(0, 7) == 0), "rand", acc);
         end
         for (int n = 0; n < ws + 3; n++)
            bus_cycle(d, ws, 1'b0, T_IDLE, 1'b0, 32'h0, 1'b0, "drain", acc);
         drv(d, 0, 0, T_IDLE, 0, 32'h0, 32'h0, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
